// File: rtl/i8253_ctl_pkg.sv
// rtl/i8253_ctl_pkg.sv - shared types and constants for the i8253 bus sequencer
package i8253_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOV,
        FIN
    } state_t;

    localparam logic       OP_LOAD   = 1'b0;
    localparam logic       OP_READ   = 1'b1;
    localparam logic [1:0] CW_ADDR   = 2'b11;
    localparam logic [1:0] RL_LATCH  = 2'b00;
    localparam logic [1:0] RL_LSBMSB = 2'b11;

    // Load control word: counter select, LSB-then-MSB access, mode, BCD flag
    function automatic logic [7:0] ctrl_word(input logic [1:0] sel,
                                             input logic [2:0] mode,
                                             input logic       bcd);
        return {sel, RL_LSBMSB, mode, bcd};
    endfunction

endpackage

// File: rtl/i8253_ctl_if.sv
// rtl/i8253_ctl_if.sv - host-port bus between the sequencer and the i8253 timer
interface i8253_ctl_if;
    logic       t_cs;
    logic       t_rd;
    logic       t_wr;
    logic [1:0] t_a;
    logic [7:0] t_wdata;
    logic [7:0] t_rdata;

    modport master (output t_cs, t_rd, t_wr, t_a, t_wdata, input t_rdata);
    modport slave  (input t_cs, t_rd, t_wr, t_a, t_wdata, output t_rdata);
endinterface

// File: rtl/i8253_rr_arb.sv
// rtl/i8253_rr_arb.sv - round-robin arbiter, first requester at or after ptr wins
module i8253_rr_arb #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/i8253_ctl.sv
// rtl/i8253_ctl.sv - arbitrated load/read sequencer for the i8253 host port
module i8253_ctl
    import i8253_ctl_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int RECOVERY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    op,
    input  logic [2*NREQ-1:0]  sel,
    input  logic [3*NREQ-1:0]  mode,
    input  logic [NREQ-1:0]    bcd,
    input  logic [16*NREQ-1:0] value,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic [15:0]        rdata,
    output logic               busy,
    i8253_ctl_if.master        tbus
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RCW = (RECOVERY > 1) ? $clog2(RECOVERY) : 1;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur_idx;
    logic [IW-1:0]   arb_idx;
    logic [NREQ-1:0] arb_grant;
    logic            arb_valid;
    logic [1:0]      step;
    logic [RCW-1:0]  rcnt;
    logic            cur_op;
    logic            cur_bcd;
    logic            cur_err;
    logic [1:0]      cur_sel;
    logic [1:0]      req_sel;
    logic [2:0]      cur_mode;
    logic [15:0]     cur_val;
    logic [15:0]     rbuf;
    logic            cs_q;
    logic            rd_q;
    logic            wr_q;
    logic [1:0]      a_q;
    logic [1:0]      step_a;
    logic [7:0]      wdata_q;
    logic [7:0]      step_wdata;

    i8253_rr_arb #(.N(NREQ), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign req_sel = sel[2*int'(arb_idx) +: 2];

    always_comb begin
        step_a     = CW_ADDR;
        step_wdata = '0;
        if (step == 2'd0) begin
            step_wdata = (cur_op == OP_LOAD) ? ctrl_word(cur_sel, cur_mode, cur_bcd)
                                             : {cur_sel, RL_LATCH, 4'b0000};
        end else begin
            step_a = cur_sel;
            if (cur_op == OP_LOAD)
                step_wdata = (step == 2'd1) ? cur_val[7:0] : cur_val[15:8];
        end
    end

    // Bus outputs are registered decodes of the state, so they trail it by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            cur_idx  <= '0;
            step     <= '0;
            rcnt     <= '0;
            cur_op   <= 1'b0;
            cur_bcd  <= 1'b0;
            cur_err  <= 1'b0;
            cur_sel  <= '0;
            cur_mode <= '0;
            cur_val  <= '0;
            rbuf     <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            rdata    <= '0;
            cs_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            a_q      <= '0;
            wdata_q  <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    cs_q <= 1'b0;
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                    if (arb_valid) begin
                        gnt      <= arb_grant;
                        busy     <= 1'b1;
                        cur_idx  <= arb_idx;
                        cur_op   <= op[arb_idx];
                        cur_sel  <= req_sel;
                        cur_mode <= mode[3*int'(arb_idx) +: 3];
                        cur_bcd  <= bcd[arb_idx];
                        cur_val  <= value[16*int'(arb_idx) +: 16];
                        cur_err  <= (req_sel == 2'd3);
                        ptr      <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                        step     <= '0;
                        rcnt     <= '0;
                        state    <= (req_sel == 2'd3) ? FIN : SETUP;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SETUP: begin
                    cs_q    <= 1'b1;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    a_q     <= step_a;
                    wdata_q <= step_wdata;
                    state   <= STROBE;
                end
                STROBE: begin
                    cs_q  <= 1'b1;
                    wr_q  <= (step == 2'd0) || (cur_op == OP_LOAD);
                    rd_q  <= (step != 2'd0) && (cur_op == OP_READ);
                    rcnt  <= '0;
                    state <= RECOV;
                end
                RECOV: begin
                    cs_q <= 1'b0;
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                    // rd_q is high only in the first RECOV cycle: the edge ending the visible strobe
                    if (rd_q) begin
                        if (step == 2'd1) rbuf[7:0]  <= tbus.t_rdata;
                        else              rbuf[15:8] <= tbus.t_rdata;
                    end
                    if (rcnt == RCW'(RECOVERY - 1)) begin
                        rcnt <= '0;
                        if (step == 2'd2) begin
                            state <= FIN;
                        end else begin
                            step  <= step + 2'd1;
                            state <= SETUP;
                        end
                    end else begin
                        rcnt <= rcnt + RCW'(1);
                    end
                end
                FIN: begin
                    done[cur_idx] <= 1'b1;
                    err           <= cur_err;
                    if (!cur_err && cur_op == OP_READ) rdata <= rbuf;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tbus.t_cs    = cs_q;
    assign tbus.t_rd    = rd_q;
    assign tbus.t_wr    = wr_q;
    assign tbus.t_a     = a_q;
    assign tbus.t_wdata = wdata_q;

endmodule
